// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with registered read port, watermark flags, fill count,
// sticky overflow/underflow flags and synchronous flush.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int AF_LEVEL   = 60,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] buf_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  out_valid,
    output logic                  buf_empty,
    output logic                  buf_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fifo_counter,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] CNT_AE   = (ADDR_WIDTH + 1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] buf_out_q, buf_out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc, wr_acc;

    // Status is decoded from the registered count only, never from requests.
    assign buf_empty    = (count_q == '0);
    assign buf_full     = (count_q == CNT_FULL);
    assign almost_empty = (count_q <= CNT_AE);
    assign almost_full  = (count_q >= CNT_AF);
    assign fifo_counter = count_q;
    assign buf_out      = buf_out_q;
    assign out_valid    = out_valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        rd_acc      = rd_en & ~buf_empty & ~flush;
        wr_acc      = wr_en & (~buf_full | rd_en) & ~flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        buf_out_d   = buf_out_q;
        out_valid_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                buf_out_d   = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (err_clr) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            // A new error in the same cycle as err_clr must not be lost.
            if (wr_en & buf_full & ~rd_en) begin
                overflow_d = 1'b1;
            end
            if (rd_en & buf_empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            buf_out_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            buf_out_q   <= buf_out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset; when full with a concurrent read and write the
    // read sees the old word at the shared pointer before it is replaced.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= buf_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: a queue model predicts read data and
// status; a negedge monitor pops expected words whenever out_valid is seen.
module tb_sync_fifo_ctrl;

    localparam int DW    = 64;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int AF    = 60;
    localparam int AE    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] buf_in = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] buf_out;
    logic          out_valid;
    logic          buf_empty, buf_full, almost_empty, almost_full;
    logic [AW:0]   fifo_counter;
    logic          err_clr = 1'b0;
    logic          overflow, underflow;

    sync_fifo_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en),
        .buf_in(buf_in), .rd_en(rd_en), .buf_out(buf_out),
        .out_valid(out_valid), .buf_empty(buf_empty), .buf_full(buf_full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .fifo_counter(fifo_counter), .err_clr(err_clr),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_out = '0;
    logic          ovf_m = 1'b0;
    logic          udf_m = 1'b0;

    function automatic void chk(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_out_valid: got buf_out 0x%0h with no read pending at %0t",
                         buf_out, $time);
            end else begin
                chk("buf_out_data", buf_out, exp_q.pop_front());
            end
        end
    end

    function automatic void check_status();
        int n;
        n = mq.size();
        chk("fifo_counter", 64'(fifo_counter), 64'(n));
        chk("buf_empty", 64'(buf_empty), 64'(n == 0));
        chk("buf_full", 64'(buf_full), 64'(n == DEPTH));
        chk("almost_empty", 64'(almost_empty), 64'(n <= AE));
        chk("almost_full", 64'(almost_full), 64'(n >= AF));
        chk("overflow", 64'(overflow), 64'(ovf_m));
        chk("underflow", 64'(underflow), 64'(udf_m));
    endfunction

    task automatic step(input logic w, input logic r, input logic f, input logic c,
                        input logic [DW-1:0] d);
        bit full_m, empty_m, racc, wacc;
        full_m  = (mq.size() == DEPTH);
        empty_m = (mq.size() == 0);
        racc    = r && !empty_m && !f;
        wacc    = w && (!full_m || r) && !f;
        wr_en = w; rd_en = r; flush = f; err_clr = c; buf_in = d;
        if (f) begin
            mq.delete();
        end else begin
            if (racc) begin
                last_out = mq.pop_front();
                exp_q.push_back(last_out);
            end
            if (wacc) mq.push_back(d);
            if (c) begin
                ovf_m = 1'b0;
                udf_m = 1'b0;
            end
            if (w && full_m && !r) ovf_m = 1'b1;
            if (r && empty_m) udf_m = 1'b1;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        check_status();
        chk("out_valid", 64'(out_valid), 64'(racc));
        if (!racc) chk("buf_out_hold", buf_out, last_out);
    endtask

    initial begin
        logic w, r;
        // Reset state
        #12;
        check_status();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_buf_out", buf_out, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset mid-operation with count 10 and a non-zero buf_out
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 64'h100 + 64'(i));
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pre_rst_count", 64'(fifo_counter), 64'd10);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        last_out = '0;
        ovf_m = 1'b0;
        udf_m = 1'b0;
        check_status();
        chk("async_rst_buf_out", buf_out, 64'd0);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);

        // Fill 0..63 then drain in order
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 64'(i));
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Full boundary: rejected write, then write-through with a read
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 64'h200 + 64'(i));
        step(1, 0, 0, 0, 64'hAA);
        step(1, 1, 0, 0, 64'hBB);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 0);
        chk("last_word_bb", last_out, 64'hBB);
        step(0, 0, 0, 0, 0);

        // Empty boundary: rejected read, then read+write+err_clr (set wins)
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 64'h77);
        chk("udf_set_wins", 64'(underflow), 64'd1);

        // Interleaved traffic across several pointer wraps, count kept in 1..63
        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (mq.size() >= DEPTH - 1 && w && !r) w = 1'b0;
            if (mq.size() <= 1 && r && !w) r = 1'b0;
            step(w, r, 0, 0, {$urandom, $urandom});
        end

        // Flush at count 30 with a concurrent write
        while (mq.size() < 30) step(1, 0, 0, 0, {$urandom, $urandom});
        while (mq.size() > 30) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 64'hDEAD);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 64'h5A);
        step(0, 1, 0, 0, 0);
        chk("post_flush_word", last_out, 64'h5A);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        total_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL scoreboard_drain: got %0d words never output, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time %0t, expected completion earlier", $time);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "timeout");
    end

endmodule
